// File: rtl/simon_block_framer.sv
// simon_block_framer: packs received bytes into 64-bit blocks for the
// combinational simon64_96 core, waits a programmable settle time, captures
// the result and unpacks it back into bytes for the transmit FIFO.
module simon_block_framer #(
    parameter int unsigned CIPHER_LAT = 1,
    parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
    input  logic        clk_100MHz,
    input  logic        reset_n,
    input  logic        rx_empty,
    input  logic [7:0]  rx_data,
    output logic        rd_uart,
    input  logic        tx_full,
    output logic [7:0]  wr_data,
    output logic        wr_uart,
    input  logic        flush,
    output logic [63:0] cipher_in,
    input  logic [63:0] cipher_out,
    output logic        busy,
    output logic [15:0] blk_count
);

    typedef enum logic [1:0] {
        COLLECT,
        SETTLE,
        EMIT
    } state_t;

    localparam logic [3:0] LAT_LAST = 4'(CIPHER_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;
    logic [3:0]  out_idx_q, out_idx_d;
    logic [63:0] cipher_in_q, cipher_in_d;
    logic [63:0] result_q, result_d;
    logic [15:0] blk_count_q, blk_count_d;
    logic [3:0]  fill_cnt;

    // State register with asynchronous active-low reset
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= COLLECT;
            byte_cnt_q  <= '0;
            lat_cnt_q   <= '0;
            out_idx_q   <= '0;
            cipher_in_q <= '0;
            result_q    <= '0;
            blk_count_q <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            out_idx_q   <= out_idx_d;
            cipher_in_q <= cipher_in_d;
            result_q    <= result_d;
            blk_count_q <= blk_count_d;
        end
    end

    // Next-state logic: byte packing, padding on flush, settle count, emission
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        out_idx_d   = out_idx_q;
        cipher_in_d = cipher_in_q;
        result_d    = result_q;
        blk_count_d = blk_count_q;
        fill_cnt    = byte_cnt_q;

        unique case (state_q)
            COLLECT: begin
                if (rd_uart) begin
                    for (int unsigned i = 0; i < 8; i++) begin
                        if (32'(byte_cnt_q) == i) begin
                            cipher_in_d[(7 - i) * 8 +: 8] = rx_data;
                        end
                    end
                    fill_cnt = byte_cnt_q + 4'd1;
                end
                byte_cnt_d = fill_cnt;
                // A full block wins over flush, so flush on the 8th pop pads nothing
                if (fill_cnt == 4'd8) begin
                    state_d   = SETTLE;
                    lat_cnt_d = '0;
                end else if (flush && (fill_cnt != '0)) begin
                    for (int unsigned i = 0; i < 8; i++) begin
                        if (i >= 32'(fill_cnt)) begin
                            cipher_in_d[(7 - i) * 8 +: 8] = PAD_BYTE;
                        end
                    end
                    byte_cnt_d = 4'd8;
                    state_d    = SETTLE;
                    lat_cnt_d  = '0;
                end
            end
            SETTLE: begin
                lat_cnt_d = lat_cnt_q + 4'd1;
                if (lat_cnt_q == LAT_LAST) begin
                    result_d  = cipher_out;
                    out_idx_d = '0;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (wr_uart) begin
                    out_idx_d = out_idx_q + 4'd1;
                    if (out_idx_q == 4'd7) begin
                        blk_count_d = blk_count_q + 16'd1;
                        byte_cnt_d  = '0;
                        state_d     = COLLECT;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Output logic: FIFO strobes, MSB-first byte select, status
    always_comb begin
        rd_uart   = (state_q == COLLECT) && !rx_empty && (byte_cnt_q < 4'd8);
        wr_uart   = (state_q == EMIT) && !tx_full;
        wr_data   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (32'(out_idx_q) == i) begin
                wr_data = result_q[(7 - i) * 8 +: 8];
            end
        end
        busy      = (state_q != COLLECT) || (byte_cnt_q != '0);
        cipher_in = cipher_in_q;
        blk_count = blk_count_q;
    end

endmodule
